// File: rtl/pipe_mux_pkg.sv
// Shared types and default sizes for the registered NUM_IN:1 pipeline mux stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_mux_pkg;

    // Occupancy of the stage: nothing held, output register only, or output plus skid entry.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam int DATA_W = 32;
    localparam int MUX_IN = 4;

endpackage

// File: rtl/mux_nx1.sv
// Combinational NUM_IN:1 select; an out-of-range sel yields zero data and raises err.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller qualifies use of the result.
// Ports: in_data (NUM_IN packed lanes, lane k at [k*WIDTH +: WIDTH]), sel, out_data, err.
module mux_nx1 #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    err
);

    // Loop compare keeps every part-select in range, even for sel values past NUM_IN-1.
    always_comb begin
        out_data = '0;
        err      = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel) == k) begin
                out_data = in_data[k*WIDTH +: WIDTH];
                err      = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_mux_stage.sv
// Registered NUM_IN:1 mux stage with valid/ready handshake and a one-entry skid buffer.
// Latency: 1 cycle from accept to out_data when the output register is free.
// Backpressure: in_ready is registered; it drops only when both output and skid are occupied.
// Ports: clk, rst_n (sync, active-low), in_data/sel/in_valid/in_ready upstream,
//        out_data/out_valid/out_ready downstream, flush, sel_err pulse.
// Optional: define PIPE_MUX_PARITY_EN to add out_par (XOR reduction of the held data).
module pipe_mux_stage
    import pipe_mux_pkg::*;
#(
    parameter int  WIDTH  = DATA_W,
    parameter int  NUM_IN = MUX_IN,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    sel_err
`ifdef PIPE_MUX_PARITY_EN
    ,
    output logic                    out_par
`endif
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mux_dat;
    logic [WIDTH-1:0] skid_data;
    logic             mux_err;
    logic             accept;
    logic             xfer;
    logic             load_out;
    logic             load_skid;
    logic             move_skid;

    mux_nx1 #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .in_data  (in_data),
        .sel      (sel),
        .out_data (mux_dat),
        .err      (mux_err)
    );

    assign accept    = in_valid && in_ready;
    assign out_valid = (state != EMPTY);
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = FULL;
                        load_out  = 1'b1;
                    end
                end
                FULL: begin
                    if (accept && xfer) begin
                        load_out = 1'b1;
                    end else if (accept) begin
                        state_nxt = SKID;
                        load_skid = 1'b1;
                    end else if (xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                SKID: begin
                    if (xfer) begin
                        state_nxt = FULL;
                        move_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_data  <= '0;
            skid_data <= '0;
            sel_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            // in_ready mirrors the next occupancy so no path exists from out_ready.
            in_ready  <= (state_nxt != SKID);
            sel_err   <= accept && mux_err && !flush;
            if (load_out) begin
                out_data <= mux_dat;
            end else if (move_skid) begin
                out_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= mux_dat;
            end
        end
    end

`ifdef PIPE_MUX_PARITY_EN
    logic skid_par;

    // Parity is taken at capture and travels with its data through the skid entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_par  <= 1'b0;
            skid_par <= 1'b0;
        end else begin
            if (load_out) begin
                out_par <= ^mux_dat;
            end else if (move_skid) begin
                out_par <= skid_par;
            end
            if (load_skid) begin
                skid_par <= ^mux_dat;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_mux_stage.sv
// Self-checking bench for pipe_mux_stage: a NUM_IN=4 and a NUM_IN=3 instance side by side.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised through directed vectors and a randomized queue-model run.
module tb_pipe_mux_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // NUM_IN = 4 instance
    logic [127:0] a_in_data;
    logic [1:0]   a_sel;
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, a_sel_err;
    logic [31:0]  a_out_data;
    // NUM_IN = 3 instance
    logic [95:0]  b_in_data;
    logic [1:0]   b_sel;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_sel_err;
    logic [31:0]  b_out_data;
`ifdef PIPE_MUX_PARITY_EN
    logic a_out_par, b_out_par;
`endif

    pipe_mux_stage #(.WIDTH(32), .NUM_IN(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .sel(a_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .flush(a_flush),
        .sel_err(a_sel_err)
`ifdef PIPE_MUX_PARITY_EN
        , .out_par(a_out_par)
`endif
    );

    pipe_mux_stage #(.WIDTH(32), .NUM_IN(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .flush(b_flush),
        .sel_err(b_sel_err)
`ifdef PIPE_MUX_PARITY_EN
        , .out_par(b_out_par)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic        vld;
        logic        ordy;
        logic        fl;
        logic        e_vld;
        logic [31:0] e_dat;
        logic        e_rdy;
    } vec_t;

    vec_t vt[12];

    // Behavioural model: the stage is a queue of at most two entries.
    logic [31:0] q[$];

    initial begin
        a_in_data = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        a_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_data = {32'h33333333, 32'h22222222, 32'h11111111};
        b_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;

        //          sel    vld   ordy  fl    e_vld e_dat          e_rdy
        vt[0]  = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'hCCCCCCCC, 1'b1}; // basic select
        vt[1]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1}; // drain to empty
        vt[2]  = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b1}; // fill, stalled
        vt[3]  = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b0}; // into skid
        vt[4]  = '{2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b0}; // held, not accepted
        vt[5]  = '{2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 32'hBBBBBBBB, 1'b1}; // skid moves up
        vt[6]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1}; // drain
        vt[7]  = '{2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDDDDDDDD, 1'b1};
        vt[8]  = '{2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hBBBBBBBB, 1'b1}; // accept + transfer
        vt[9]  = '{2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 32'hBBBBBBBB, 1'b0}; // into skid
        vt[10] = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1}; // flush in skid with accept
        vt[11] = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1}; // nothing emerges

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst a_out_valid", a_out_valid, 0);
        chk("rst a_out_data", a_out_data, 0);
        chk("rst a_in_ready", a_in_ready, 1);
        chk("rst a_sel_err", a_sel_err, 0);
        chk("rst b_out_valid", b_out_valid, 0);
        chk("rst b_in_ready", b_in_ready, 1);
        rst_n = 1'b1;

        // Directed vector table on the 4-input stage
        for (int i = 0; i < 12; i++) begin
            a_sel = vt[i].sel; a_in_valid = vt[i].vld;
            a_out_ready = vt[i].ordy; a_flush = vt[i].fl;
            tick();
            chk($sformatf("vec%0d out_valid", i), a_out_valid, vt[i].e_vld);
            chk($sformatf("vec%0d in_ready", i), a_in_ready, vt[i].e_rdy);
            chk($sformatf("vec%0d sel_err", i), a_sel_err, 0);
            if (vt[i].e_vld) chk($sformatf("vec%0d out_data", i), a_out_data, vt[i].e_dat);
        end
        a_flush = 1'b0;

        // Reset in the middle of a stream
        a_sel = 2'd0; a_in_valid = 1'b1; a_out_ready = 1'b1;
        tick();
        chk("mid fill valid", a_out_valid, 1);
        rst_n = 1'b0; a_in_valid = 1'b0;
        tick();
        chk("mid rst out_valid", a_out_valid, 0);
        chk("mid rst out_data", a_out_data, 0);
        chk("mid rst in_ready", a_in_ready, 1);
        rst_n = 1'b1; a_sel = 2'd1; a_in_valid = 1'b1;
        tick();
        chk("post rst valid", a_out_valid, 1);
        chk("post rst data", a_out_data, 32'hBBBBBBBB);
        a_in_valid = 1'b0;
        tick();
        chk("post rst drain", a_out_valid, 0);

        // Out-of-range select on the 3-input stage
        b_sel = 2'd3; b_in_valid = 1'b1; b_out_ready = 1'b1;
        tick();
        chk("oob out_valid", b_out_valid, 1);
        chk("oob out_data", b_out_data, 0);
        chk("oob sel_err", b_sel_err, 1);
        b_in_valid = 1'b0;
        tick();
        chk("oob sel_err one cycle", b_sel_err, 0);
        chk("oob drained", b_out_valid, 0);
        // Flush suppresses both the accept and the error pulse
        b_in_valid = 1'b1; b_flush = 1'b1;
        tick();
        chk("flush oob sel_err", b_sel_err, 0);
        chk("flush oob out_valid", b_out_valid, 0);
        chk("flush oob in_ready", b_in_ready, 1);
        b_in_valid = 1'b0; b_flush = 1'b0;
        tick();

`ifdef PIPE_MUX_PARITY_EN
        a_in_data = {32'h0, 32'h0, 32'h00000003, 32'h00000007};
        a_sel = 2'd0; a_in_valid = 1'b1; a_out_ready = 1'b1;
        tick();
        chk("par 7", a_out_par, 1);
        a_sel = 2'd1;
        tick();
        chk("par 3", a_out_par, 0);
        a_in_valid = 1'b0;
        tick();
`endif

        // Randomized run on the 3-input stage against the queue model
        q.delete();
        for (int n = 0; n < 400; n++) begin
            logic        acc, xf, err_exp;
            logic [31:0] val;
            int          s;
            b_in_data   = {$urandom, $urandom, $urandom};
            s           = $urandom_range(0, 3);
            b_sel       = 2'(s);
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_flush     = ($urandom_range(0, 19) == 0);
            acc     = b_in_valid && (q.size() < 2);
            xf      = (q.size() > 0) && b_out_ready;
            val     = (s < 3) ? b_in_data[s*32 +: 32] : 32'h0;
            err_exp = acc && (s >= 3) && !b_flush;
            if (b_flush) begin
                q.delete();
            end else begin
                if (xf) void'(q.pop_front());
                if (acc) q.push_back(val);
            end
            tick();
            chk("rnd out_valid", b_out_valid, (q.size() > 0));
            chk("rnd in_ready", b_in_ready, (q.size() < 2));
            chk("rnd sel_err", b_sel_err, err_exp);
            if (q.size() > 0) begin
                chk("rnd out_data", b_out_data, q[0]);
`ifdef PIPE_MUX_PARITY_EN
                chk("rnd out_par", b_out_par, ^q[0]);
`endif
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
